// File: rtl/audio_mixer.sv
// Multi-channel oscillator mixer: per-channel saw/triangle/square generators,
// attenuated and panned into saturating stereo accumulators, one sample per tick.
module audio_mixer #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned PHASE_W  = 24
) (
    input  logic                        sys_clk,
    input  logic                        reset,
    input  logic                        sample_tick,
    input  logic                        cfg_we,
    input  logic [$clog2(CHANNELS)-1:0] cfg_ch,
    input  logic [1:0]                  cfg_sel,
    input  logic [PHASE_W-1:0]          cfg_data,
    output logic [DATA_W-1:0]           out_left,
    output logic [DATA_W-1:0]           out_right,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        clip_l,
    output logic                        clip_r,
    output logic                        overrun
);

    localparam int unsigned CW = $clog2(CHANNELS);
    localparam int unsigned AW = DATA_W + CW + 1;

    // Half scale: the pattern 100..0 is -H as signed and H as unsigned.
    localparam logic [DATA_W-1:0] H_PAT   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] HM1_PAT = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] MAX_S = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_S = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        SAT  = 2'd2,
        OUT  = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0] acc_l_q, acc_l_d;
    logic signed [AW-1:0] acc_r_q, acc_r_d;
    logic [DATA_W-1:0]    out_left_q, out_left_d;
    logic [DATA_W-1:0]    out_right_q, out_right_d;
    logic                 out_valid_q, out_valid_d;
    logic                 clip_l_q, clip_l_d;
    logic                 clip_r_q, clip_r_d;
    logic                 overrun_q, overrun_d;

    logic [PHASE_W-1:0] incr_q  [CHANNELS];
    logic [PHASE_W-1:0] incr_d  [CHANNELS];
    logic [1:0]         mode_q  [CHANNELS];
    logic [1:0]         mode_d  [CHANNELS];
    logic [3:0]         atten_q [CHANNELS];
    logic [3:0]         atten_d [CHANNELS];
    logic [1:0]         pan_q   [CHANNELS];
    logic [1:0]         pan_d   [CHANNELS];
    logic [PHASE_W-1:0] phase_q [CHANNELS];
    logic [PHASE_W-1:0] phase_d [CHANNELS];

    logic [DATA_W-1:0]        ch_p;
    logic [DATA_W-1:0]        ch_fold;
    logic [DATA_W-1:0]        ch_wave;
    logic signed [DATA_W-1:0] ch_shift;
    logic signed [AW-1:0]     ch_ext;

    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign out_valid = out_valid_q;
    assign clip_l    = clip_l_q;
    assign clip_r    = clip_r_q;
    assign overrun   = overrun_q;

    // Waveform of the channel currently selected by the MIX counter.
    always_comb begin
        ch_p    = phase_q[cnt_q][PHASE_W-1 -: DATA_W];
        ch_fold = ch_p[DATA_W-1] ? ~ch_p : ch_p;
        ch_wave = '0;
        case (mode_q[cnt_q])
            2'd1:    ch_wave = ch_p - H_PAT;
            2'd2:    ch_wave = DATA_W'(ch_fold << 1) - H_PAT;
            2'd3:    ch_wave = ch_p[DATA_W-1] ? H_PAT : HM1_PAT;
            default: ch_wave = '0;
        endcase
        ch_shift = $signed(ch_wave) >>> atten_q[cnt_q];
        ch_ext   = {{(AW-DATA_W){ch_shift[DATA_W-1]}}, ch_shift};
    end

    // Sequencer, accumulation, saturation and configuration next-state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        out_valid_d = out_valid_q;
        clip_l_d    = clip_l_q;
        clip_r_d    = clip_r_q;
        overrun_d   = overrun_q;
        incr_d      = incr_q;
        mode_d      = mode_q;
        atten_d     = atten_q;
        pan_d       = pan_q;
        phase_d     = phase_q;

        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = MIX;
                    cnt_d   = '0;
                    acc_l_d = '0;
                    acc_r_d = '0;
                end
            end
            MIX: begin
                if (pan_q[cnt_q][0]) acc_l_d = acc_l_q + ch_ext;
                if (pan_q[cnt_q][1]) acc_r_d = acc_r_q + ch_ext;
                if (mode_q[cnt_q] != 2'd0) phase_d[cnt_q] = phase_q[cnt_q] + incr_q[cnt_q];
                if (cnt_q == CW'(CHANNELS - 1)) state_d = SAT;
                else                            cnt_d   = cnt_q + CW'(1);
            end
            SAT: begin
                if (acc_l_q > MAX_S) begin
                    out_left_d = HM1_PAT;
                    clip_l_d   = 1'b1;
                end else if (acc_l_q < MIN_S) begin
                    out_left_d = H_PAT;
                    clip_l_d   = 1'b1;
                end else begin
                    out_left_d = acc_l_q[DATA_W-1:0];
                    clip_l_d   = 1'b0;
                end
                if (acc_r_q > MAX_S) begin
                    out_right_d = HM1_PAT;
                    clip_r_d    = 1'b1;
                end else if (acc_r_q < MIN_S) begin
                    out_right_d = H_PAT;
                    clip_r_d    = 1'b1;
                end else begin
                    out_right_d = acc_r_q[DATA_W-1:0];
                    clip_r_d    = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ticks arriving while a sample is in flight are lost.
        if (sample_tick && (state_q != IDLE)) overrun_d = 1'b1;

        // Config write lands at the edge; a mode write restarts the phase.
        if (cfg_we && ({1'b0, cfg_ch} < (CW+1)'(CHANNELS))) begin
            case (cfg_sel)
                2'd0: incr_d[cfg_ch] = cfg_data;
                2'd1: begin
                    mode_d[cfg_ch]  = cfg_data[1:0];
                    phase_d[cfg_ch] = '0;
                end
                2'd2:    atten_d[cfg_ch] = cfg_data[3:0];
                default: pan_d[cfg_ch]   = cfg_data[1:0];
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            clip_l_q    <= 1'b0;
            clip_r_q    <= 1'b0;
            overrun_q   <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                incr_q[i]  <= '0;
                mode_q[i]  <= '0;
                atten_q[i] <= '0;
                pan_q[i]   <= 2'b11;
                phase_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            out_valid_q <= out_valid_d;
            clip_l_q    <= clip_l_d;
            clip_r_q    <= clip_r_d;
            overrun_q   <= overrun_d;
            incr_q      <= incr_d;
            mode_q      <= mode_d;
            atten_q     <= atten_d;
            pan_q       <= pan_d;
            phase_q     <= phase_d;
        end
    end

endmodule

// File: tb/tb_audio_mixer.sv
// Scoreboard bench for audio_mixer: stimulus pushes model results, monitor pops on handshake.
module tb_audio_mixer;

    localparam int CH = 4;
    localparam int DW = 24;
    localparam int PW = 24;
    localparam longint H    = longint'(1) << (DW - 1);
    localparam longint PMOD = longint'(1) << PW;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample_tick = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [1:0]    cfg_sel = '0;
    logic [PW-1:0] cfg_data = '0;
    logic [DW-1:0] out_left, out_right;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          clip_l, clip_r, overrun;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          cl;
        logic          cr;
    } exp_t;

    exp_t   exp_q[$];
    longint m_incr[CH];
    longint m_phase[CH];
    int     m_mode[CH];
    int     m_atten[CH];
    int     m_pan[CH];

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] last_l, last_r;
    logic          last_cl, last_cr;

    audio_mixer #(.CHANNELS(CH), .DATA_W(DW), .PHASE_W(PW)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .out_left    (out_left),
        .out_right   (out_right),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .clip_l      (clip_l),
        .clip_r      (clip_r),
        .overrun     (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic void check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_incr[i] = 0; m_phase[i] = 0; m_mode[i] = 0; m_atten[i] = 0; m_pan[i] = 3;
        end
    endfunction

    // Reference: one stereo sample from the channel fields, then advance phases.
    function automatic void model_push();
        longint al = 0;
        longint ar = 0;
        longint p, w;
        exp_t e;
        for (int i = 0; i < CH; i++) begin
            if (m_mode[i] != 0) begin
                p = m_phase[i] >> (PW - DW);
                case (m_mode[i])
                    1:       w = p - H;
                    2:       w = ((p < H) ? 2 * p : 2 * ((2 * H - 1) - p)) - H;
                    default: w = (p < H) ? H - 1 : -H;
                endcase
                w = w >>> m_atten[i];
                if ((m_pan[i] & 1) != 0) al += w;
                if ((m_pan[i] & 2) != 0) ar += w;
                m_phase[i] = (m_phase[i] + m_incr[i]) % PMOD;
            end
        end
        e.cl = (al > H - 1) || (al < -H);
        e.cr = (ar > H - 1) || (ar < -H);
        if (al > H - 1) al = H - 1;
        if (al < -H)    al = -H;
        if (ar > H - 1) ar = H - 1;
        if (ar < -H)    ar = -H;
        e.l = DW'(al);
        e.r = DW'(ar);
        exp_q.push_back(e);
    endfunction

    task automatic cfg(input int ch, input int sel, input longint data);
        @(posedge sys_clk); #1;
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_sel = 2'(sel); cfg_data = PW'(data);
        @(posedge sys_clk); #1;
        cfg_we = 1'b0;
        case (sel)
            0: m_incr[ch] = data % PMOD;
            1: begin m_mode[ch] = int'(data & 3); m_phase[ch] = 0; end
            2: m_atten[ch] = int'(data & 15);
            default: m_pan[ch] = int'(data & 3);
        endcase
    endtask

    // Issue one accepted tick; optionally measure tick-to-valid latency.
    task automatic issue_tick(input bit check_lat);
        int n;
        bit found;
        @(posedge sys_clk); #1;
        sample_tick = 1'b1;
        model_push();
        @(posedge sys_clk); #1;
        sample_tick = 1'b0;
        if (check_lat) begin
            n = 0; found = 0;
            while (n < 20 && !found) begin
                @(negedge sys_clk);
                n++;
                if (out_valid) found = 1;
            end
            check("latency", found ? n : -1, 6);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Monitor: pop and compare on each handshake; hold outputs stable while stalled.
    bit            hold = 0;
    logic [DW-1:0] h_l, h_r;
    logic          h_cl, h_cr;
    always @(negedge sys_clk) begin
        exp_t e;
        if (!reset) begin
            hold = 0;
        end else begin
            if (hold)
                check("hold_stable", {out_valid, out_left, out_right, clip_l, clip_r},
                      {1'b1, h_l, h_r, h_cl, h_cr});
            if (out_valid && out_ready) begin
                hold = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_left", out_left, e.l);
                    check("out_right", out_right, e.r);
                    check("clip_l", clip_l, e.cl);
                    check("clip_r", clip_r, e.cr);
                    last_l = out_left; last_r = out_right; last_cl = clip_l; last_cr = clip_r;
                end
            end else if (out_valid) begin
                hold = 1;
                h_l = out_left; h_r = out_right; h_cl = clip_l; h_cr = clip_r;
            end else begin
                hold = 0;
            end
        end
    end

    initial begin
        bit seen;
        model_reset();
        #2 reset = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_out_left", out_left, 0);
        check("rst_out_right", out_right, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_clip", {clip_l, clip_r}, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b1;

        // All channels off: silent sample.
        issue_tick(1);
        drain();
        check("off_left", last_l, 0);
        check("off_right", last_r, 0);

        // Single sawtooth channel over three samples.
        cfg(0, 0, 64'h100000);
        cfg(0, 1, 1);
        issue_tick(1); drain();
        check("saw1_left", last_l, 24'h800000);
        check("saw1_right", last_r, 24'h800000);
        issue_tick(1); drain();
        check("saw2_left", last_l, 24'h900000);
        issue_tick(1); drain();
        check("saw3_phase", last_l, 24'hA00000);

        // Two full-scale squares on the left only: positive clip.
        cfg(0, 1, 3); cfg(0, 3, 1);
        cfg(1, 1, 3); cfg(1, 3, 1);
        issue_tick(1); drain();
        check("sq_left", last_l, 24'h7FFFFF);
        check("sq_clip_l", last_cl, 1);
        check("sq_right", last_r, 0);
        check("sq_clip_r", last_cr, 0);

        // Attenuated square on the right only.
        cfg(0, 1, 0); cfg(1, 1, 0);
        cfg(2, 1, 3); cfg(2, 2, 4); cfg(2, 3, 2);
        issue_tick(1); drain();
        check("att_right", last_r, 24'h07FFFF);
        check("att_left", last_l, 0);

        // Stalled output with a dropped tick.
        cfg(2, 1, 0);
        cfg(0, 1, 1); cfg(0, 3, 3);
        @(posedge sys_clk); #1 out_ready = 1'b0;
        issue_tick(1);
        repeat (2) @(posedge sys_clk);
        #1 sample_tick = 1'b1;
        @(posedge sys_clk); #1 sample_tick = 1'b0;
        @(negedge sys_clk);
        check("ovr_flag", overrun, 1);
        check("ovr_valid", out_valid, 1);
        check("ovr_left_held", out_left, 24'h800000);
        @(posedge sys_clk); #1 out_ready = 1'b1;
        drain();
        issue_tick(1); drain();
        check("ovr_no_advance", last_l, 24'h900000);
        check("ovr_sticky", overrun, 1);

        // Reset during the second MIX cycle aborts the sample.
        issue_tick(0);
        @(posedge sys_clk); #2;
        reset = 1'b0;
        #1;
        check("abort_left", out_left, 0);
        check("abort_right", out_right, 0);
        check("abort_valid", out_valid, 0);
        check("abort_overrun", overrun, 0);
        exp_q.delete();
        model_reset();
        @(posedge sys_clk); #1 reset = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge sys_clk);
            if (out_valid) seen = 1;
        end
        check("abort_no_valid", seen, 0);
        issue_tick(1); drain();
        check("abort_cfg_cleared", {last_l, last_r}, 0);

        // Randomized configurations with random output stalls.
        for (int round = 0; round < 4; round++) begin
            for (int c = 0; c < CH; c++) begin
                cfg(c, 0, longint'($urandom) % PMOD);
                cfg(c, 1, $urandom_range(0, 3));
                cfg(c, 2, $urandom_range(0, 15));
                cfg(c, 3, $urandom_range(0, 3));
            end
            for (int s = 0; s < 6; s++) begin
                @(posedge sys_clk); #1 out_ready = 1'($urandom_range(0, 1));
                issue_tick(1);
                if (!out_ready) begin
                    repeat ($urandom_range(1, 4)) @(posedge sys_clk);
                    #1 out_ready = 1'b1;
                end
                drain();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_mixer.md
AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 The block SHALL have parameters CHANNELS, default 4, giving the number of oscillator channels (2..16).
REQ-002 The block SHALL have parameter DATA_W, default 24, giving the sample width (signed, two's complement).
REQ-003 The block SHALL have parameter PHASE_W, default 24, giving the phase accumulator width (PHASE_W >= DATA_W).
REQ-004 Port sys_clk, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port sample_tick, input, 1 bit: one-cycle pulse requesting one stereo sample.
REQ-007 Port cfg_we, input, 1 bit: configuration write strobe.
REQ-008 Port cfg_ch, input, clog2(CHANNELS) bits: channel index for the write.
REQ-009 Port cfg_sel, input, 2 bits: field select; 0=incr, 1=mode, 2=atten, 3=pan.
REQ-010 Port cfg_data, input, PHASE_W bits: write data, LSB-aligned.
REQ-011 Port out_left and port out_right, output, DATA_W bits each: mixed signed samples.
REQ-012 Port out_valid, output, 1 bit; port out_ready, input, 1 bit: output handshake.
REQ-013 Port clip_l and port clip_r, output, 1 bit each: saturation occurred on the presented sample.
REQ-014 Port overrun, output, 1 bit: sticky flag, set when a sample_tick is dropped.

Function
REQ-015 Each channel SHALL hold incr (PHASE_W), mode (2 bits: 0=off, 1=saw, 2=triangle, 3=square), atten (4 bits), pan (2 bits: bit0=left enable, bit1=right enable), and phase (PHASE_W).
REQ-016 A cfg_we write SHALL update the selected field at the next edge; a write to mode SHALL also clear that channel's phase to 0.
REQ-017 FSM states SHALL be IDLE, MIX, SAT and OUT; IDLE goes to MIX on sample_tick, MIX goes to SAT after CHANNELS cycles, SAT goes to OUT after 1 cycle, and OUT goes to IDLE when out_valid && out_ready.
REQ-018 MIX SHALL process channel k in its k-th cycle, using the field values present in that cycle.
REQ-019 Waveform generation SHALL use p = phase[PHASE_W-1 -: DATA_W] and H = 2^(DATA_W-1):
  - saw = p - H
  - triangle = ((p[MSB] ? ~p : p) << 1) - H
  - square = p[MSB] ? -H : H-1
  - off = 0
REQ-020 The channel value SHALL be the waveform arithmetically shifted right by atten, then added to the left and/or right accumulator according to pan.
REQ-021 Accumulators SHALL be DATA_W+clog2(CHANNELS)+1 bits wide and SHALL be cleared on entry to MIX.
REQ-022 After a channel is processed, its phase SHALL advance by incr modulo 2^PHASE_W; phase SHALL be held when mode is off.
REQ-023 SAT SHALL clamp each accumulator to [-H, H-1], register the results to out_left/out_right, and set clip_l/clip_r when clamping occurred.
REQ-024 The latency from sample_tick (in IDLE) at cycle T to out_valid=1 SHALL be cycle T+CHANNELS+2.
REQ-025 out_valid SHALL remain high, and out_left/out_right/clip_* SHALL remain stable, until the handshake completes.
REQ-026 out_valid SHALL deassert on the cycle after the handshake; the held output values SHALL remain until the next SAT.
REQ-027 A sample_tick received in MIX, SAT or OUT SHALL be dropped (no phase advance) and SHALL set overrun.
REQ-028 A sample_tick in the same cycle as the completing handshake SHALL be dropped; the FSM goes to IDLE.
REQ-029 A cfg_we that coincides with a MIX read of the same channel SHALL leave the old value in use for that sample.

Reset
REQ-030 While reset=0, all channel fields, phases, accumulators, out_left, out_right, out_valid, clip_l, clip_r and overrun SHALL be 0, except pan, which SHALL be 2'b11; the FSM SHALL be in IDLE.
REQ-031 A reset asserted mid-operation SHALL abort the current sample immediately, with no output produced.
REQ-032 overrun SHALL be cleared only by reset.

Verification (CHANNELS=4, DATA_W=24, PHASE_W=24)
REQ-033 Bench SHALL cover: release reset, hold out_ready=1, all channels off, tick at T -> out_valid=1 at T+6, out_left=out_right=0, clip_l=clip_r=0.
REQ-034 Bench SHALL cover: ch0 mode=saw, incr=0x100000 -> first sample both outputs 0x800000; second sample both 0x900000; ch0 phase reads 0x200000.
REQ-035 Bench SHALL cover: ch0 and ch1 square, pan=1, atten=0 -> out_left=0x7FFFFF, clip_l=1, out_right=0, clip_r=0.
REQ-036 Bench SHALL cover: ch2 square, atten=4, pan=2, others off -> out_right=0x07FFFF, out_left=0.
REQ-037 Bench SHALL cover: out_ready=0, second tick while OUT -> outputs unchanged, overrun=1, ch0 phase not advanced by the dropped tick.
REQ-038 Bench SHALL cover: reset pulsed during MIX cycle 2 -> all outputs 0 asynchronously, FSM in IDLE, no out_valid afterward until a new tick.
